// File: rtl/icache_2way_if.sv
// Fetch-side and memory-side signals of the two-way instruction cache.
// The cache uses the slave modport. The fetch stage and mem_ctrl use the master modport.
interface icache_2way_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              flush;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_inst;
    logic              stallreq;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_busy;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output req_valid, req_addr, flush, mem_busy, mem_rvalid, mem_rdata,
        input  resp_valid, resp_inst, stallreq, mem_req, mem_addr
    );

    modport slave (
        input  req_valid, req_addr, flush, mem_busy, mem_rvalid, mem_rdata,
        output resp_valid, resp_inst, stallreq, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_2way.sv
// Two-way set-associative I-cache: combinational hits, word-by-word line refill, per-set LRU.
// Defining ICACHE_PERF_EN adds the hit_cnt/miss_cnt performance counter ports.
module icache_2way #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input logic          clk,
    input logic          rst,
    icache_2way_if.slave bus
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
`endif
);
    localparam int OFF_W = $clog2(LINE_WORDS) + 2;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_MEM, REFILL} state_t;
    state_t state, state_nx;

    logic [SETS-1:0]   valid [2];
    logic [SETS-1:0]   lru;
    logic [TAG_W-1:0]  tag_mem [2][SETS];
    logic [DATA_W-1:0] data_mem [2][SETS][LINE_WORDS];

    logic [CNT_W-1:0]  cnt;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] base;
    logic              victim;
    logic              flush_pend;

    logic [IDX_W-1:0]  idx, fill_idx;
    logic [TAG_W-1:0]  tag, fill_tag;
    logic [CNT_W-1:0]  word_sel;
    logic              hit0, hit1, lookup, hit, miss, last, victim_nx;

    always_comb begin
        idx       = IDX_W'(bus.req_addr >> OFF_W);
        tag       = TAG_W'(bus.req_addr >> (OFF_W + IDX_W));
        word_sel  = CNT_W'((bus.req_addr >> 2) & ADDR_W'(LINE_WORDS - 1));
        fill_idx  = IDX_W'(base >> OFF_W);
        fill_tag  = TAG_W'(base >> (OFF_W + IDX_W));
        hit0      = valid[0][idx] && (tag_mem[0][idx] == tag);
        hit1      = valid[1][idx] && (tag_mem[1][idx] == tag);
        // A flush cycle performs no lookup, so it can neither hit nor start a refill.
        lookup    = (state == IDLE) && bus.req_valid && !bus.flush && !rst;
        hit       = lookup && (hit0 || hit1);
        miss      = lookup && !(hit0 || hit1);
        last      = (state == REFILL) && bus.mem_rvalid && (cnt == CNT_W'(LINE_WORDS - 1));
        victim_nx = !valid[0][idx] ? 1'b0 : (!valid[1][idx] ? 1'b1 : lru[idx]);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (miss) state_nx = WAIT_MEM;
            WAIT_MEM: if (!bus.mem_busy) state_nx = REFILL;
            REFILL:   if (last) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
        bus.resp_valid = hit;
        bus.resp_inst  = hit ? data_mem[hit1][idx][word_sel] : '0;
        bus.stallreq   = bus.req_valid && !hit && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            flush_pend <= 1'b0;
            valid[0]   <= '0;
            valid[1]   <= '0;
            lru        <= '0;
        end else begin
            state <= state_nx;
            if (miss)
                flush_pend <= 1'b0;
            else if (bus.flush)
                flush_pend <= 1'b1;
            if (state == WAIT_MEM && !bus.mem_busy) begin
                mem_req_q  <= 1'b1;
                mem_addr_q <= base;
                cnt        <= '0;
            end
            if (state == REFILL && bus.mem_rvalid) begin
                cnt        <= cnt + CNT_W'(1);
                mem_addr_q <= mem_addr_q + ADDR_W'(4);
            end
            // A flush seen during the refill leaves the installed line invalid.
            if (last) begin
                mem_req_q                <= 1'b0;
                valid[victim][fill_idx]  <= !flush_pend;
                lru[fill_idx]            <= !victim;
            end
            if (hit)
                lru[idx] <= !hit1;
            if (bus.flush) begin
                valid[0] <= '0;
                valid[1] <= '0;
                lru      <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (miss) begin
            base   <= bus.req_addr & ~ADDR_W'((1 << OFF_W) - 1);
            victim <= victim_nx;
        end
        if (state == REFILL && bus.mem_rvalid)
            data_mem[victim][fill_idx][cnt] <= bus.mem_rdata;
        if (last)
            tag_mem[victim][fill_idx] <= fill_tag;
    end

    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit)  hit_cnt  <= hit_cnt + 32'd1;
            if (miss) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_icache_2way.sv
// Bench for icache_2way: table vectors, multi-cycle corner sequences and random accesses
// checked against an LRU recency-list model of the cache.
module tb_icache_2way;
    localparam int SETS = 64;
    localparam int LW   = 4;
    localparam int OFFB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    icache_2way_if #(.ADDR_W(32), .DATA_W(32)) bus ();
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    icache_2way #(.ADDR_W(32), .DATA_W(32), .SETS(SETS), .LINE_WORDS(LW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ICACHE_PERF_EN
        ,
        .hit_cnt(hit_cnt),
        .miss_cnt(miss_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;
    int lat   = 0;
    int wait_ctr = 0;
    logic [31:0] mem_log [$];
    int unsigned mlines [SETS][$];

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A_1234;
    endfunction

    // Memory responder: one word per (lat+1) cycles while mem_req is high.
    initial begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_rvalid = 1'b0;
            if (bus.mem_req) begin
                if (wait_ctr >= lat) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = mdata(bus.mem_addr);
                    mem_log.push_back(bus.mem_addr);
                    wait_ctr = 0;
                end else begin
                    wait_ctr++;
                end
            end else begin
                wait_ctr = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exhausted, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_access(input int unsigned line);
        int s;
        int pos;
        s = int'(line % SETS);
        pos = -1;
        for (int i = 0; i < mlines[s].size(); i++)
            if (mlines[s][i] == line) pos = i;
        if (pos >= 0) begin
            mlines[s].delete(pos);
            mlines[s].push_back(line);
            return 1'b1;
        end
        if (mlines[s].size() >= 2) void'(mlines[s].pop_front());
        mlines[s].push_back(line);
        return 1'b0;
    endfunction

    task automatic do_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        for (int s = 0; s < SETS; s++) mlines[s].delete();
    endtask

    // Holds a request until it is answered; cycles counts edges from the request cycle.
    task automatic access(input logic [31:0] a, output bit hit, output logic [31:0] inst,
                          output int cycles, output bit first_stall);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        cycles = 0;
        @(negedge clk);
        hit = bus.resp_valid;
        first_stall = bus.stallreq;
        while (!bus.resp_valid && cycles < 300) begin
            tick();
            @(negedge clk);
            cycles++;
        end
        inst = bus.resp_inst;
        check("access_timeout", 32'(cycles >= 300), 32'd0);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_req_low(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.mem_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n >= 200), 32'd0);
        tick();
    endtask

    task automatic wait_first_word(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (mem_log.size() < 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n >= 200), 32'd0);
        tick();
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          exp_hit;
    } vec_t;

    initial begin
        vec_t        vt [10];
        bit          h, st;
        logic [31:0] inst, a;
        int          cyc, n;
        bit          eh;

        vt[0] = '{32'h0000_010C, 1'b1};
        vt[1] = '{32'h0000_0000, 1'b0};
        vt[2] = '{32'h0000_1000, 1'b0};
        vt[3] = '{32'h0000_0000, 1'b1};
        vt[4] = '{32'h0000_2000, 1'b0};
        vt[5] = '{32'h0000_0004, 1'b1};
        vt[6] = '{32'h0000_1008, 1'b0};
        vt[7] = '{32'h0000_2004, 1'b0};
        vt[8] = '{32'h0000_0008, 1'b0};
        vt[9] = '{32'h0000_0108, 1'b1};

        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.flush     = 1'b0;
        bus.mem_busy  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_inst", bus.resp_inst, 32'd0);
        check("rst_stallreq", 32'(bus.stallreq), 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
`ifdef ICACHE_PERF_EN
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
`endif
        tick();

        // Cold miss on 0x100, then a same-line hit with no memory traffic.
        lat = 0;
        mem_log.delete();
        access(32'h100, h, inst, cyc, st);
        check("cold_hit_flag", 32'(h), 32'd0);
        check("cold_stall", 32'(st), 32'd1);
        check("cold_inst", inst, mdata(32'h100));
        check("cold_penalty", 32'(cyc), 32'(2 + LW));
        check("cold_words", 32'(mem_log.size()), 32'(LW));
        for (int i = 0; i < mem_log.size(); i++)
            check("cold_mem_addr", mem_log[i], 32'h100 + 32'(4 * i));
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h104;
        @(negedge clk);
        check("hit104_valid", 32'(bus.resp_valid), 32'd1);
        check("hit104_inst", bus.resp_inst, mdata(32'h104));
        check("hit104_mem_req", 32'(bus.mem_req), 32'd0);
        check("hit104_stall", 32'(bus.stallreq), 32'd0);
        tick();
        bus.req_valid = 1'b0;

        // Conflict and LRU replacement in set 0.
        for (int i = 0; i < 10; i++) begin
            access(vt[i].addr, h, inst, cyc, st);
            check("vec_hit", 32'(h), 32'(vt[i].exp_hit));
            check("vec_inst", inst, mdata(vt[i].addr));
        end

        // mem_busy held through the miss cycle and four WAIT_MEM cycles.
        bus.mem_busy  = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h300;
        @(negedge clk);
        check("busy_miss_stall", 32'(bus.stallreq), 32'd1);
        check("busy_miss_resp", 32'(bus.resp_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            check("busy_mem_req", 32'(bus.mem_req), 32'd0);
            check("busy_stall", 32'(bus.stallreq), 32'd1);
        end
        tick();
        bus.mem_busy = 1'b0;
        @(negedge clk);
        check("busy_fall_mem_req", 32'(bus.mem_req), 32'd0);
        tick();
        @(negedge clk);
        check("busy_first_req", 32'(bus.mem_req), 32'd1);
        check("busy_first_addr", bus.mem_addr, 32'h300);
        n = 0;
        while (!bus.resp_valid && n < 200) begin
            tick();
            @(negedge clk);
            n++;
        end
        check("busy_timeout", 32'(n >= 200), 32'd0);
        check("busy_inst", bus.resp_inst, mdata(32'h300));
        tick();
        bus.req_valid = 1'b0;

        // Flush during the second refill word of 0x200.
        lat = 1;
        mem_log.delete();
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h200;
        tick();
        bus.req_valid = 1'b0;
        wait_first_word("flush_wait_word0");
        do_flush();
        wait_req_low("flush_wait_done");
        check("flush_words", 32'(mem_log.size()), 32'(LW));
        check("flush_last_addr", mem_log[mem_log.size()-1], 32'h20C);
        access(32'h200, h, inst, cyc, st);
        check("flush_200_hit", 32'(h), 32'd0);
        check("flush_200_inst", inst, mdata(32'h200));
        access(32'h104, h, inst, cyc, st);
        check("flush_104_hit", 32'(h), 32'd0);

        // Reset in the middle of a refill.
        do_flush();
        mem_log.delete();
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h100;
        tick();
        wait_first_word("rst_wait_word0");
        bus.req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_mem_req", 32'(bus.mem_req), 32'd0);
        check("midrst_stall", 32'(bus.stallreq), 32'd0);
        check("midrst_resp", 32'(bus.resp_valid), 32'd0);
        tick();
        access(32'h100, h, inst, cyc, st);
        check("midrst_100_hit", 32'(h), 32'd0);
        check("midrst_100_inst", inst, mdata(32'h100));

        // Random accesses against the recency-list model.
        do_flush();
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 19) == 0) do_flush();
            lat = int'($urandom_range(0, 2));
            a = ((32'($urandom_range(0, 2)) * SETS + 32'($urandom_range(0, 3))) << OFFB)
                | (32'($urandom_range(0, LW - 1)) << 2);
            eh = model_access(a >> OFFB);
            mem_log.delete();
            access(a, h, inst, cyc, st);
            check("rnd_hit", 32'(h), 32'(eh));
            check("rnd_inst", inst, mdata(a));
            check("rnd_cycles", 32'(cyc), eh ? 32'd0 : 32'(2 + LW * (lat + 1)));
            check("rnd_words", 32'(mem_log.size()), eh ? 32'd0 : 32'(LW));
        end

`ifdef ICACHE_PERF_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lat = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h500;
        tick();
        bus.req_valid = 1'b0;
        wait_req_low("perf_wait_refill");
        access(32'h500, h, inst, cyc, st);
        access(32'h504, h, inst, cyc, st);
        access(32'h508, h, inst, cyc, st);
        @(negedge clk);
        check("perf_miss_cnt", miss_cnt, 32'd1);
        check("perf_hit_cnt", hit_cnt, 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
